// File: rtl/dmem_arbiter.sv
// Two-port (A = load/store unit, B = DMA/debug loader) arbiter and sequencer
// for the single-port data memory.
//
// Ports:
//   clk, reset (async, active-low)
//   a_req/a_we/a_addr/a_wdata -> a_gnt (comb), a_rvalid/a_rdata/a_err (reg)
//   b_* : same as port A
//   mem_address/mem_dataIn/mem_writeEnable -> memory, mem_dataOut <- memory
//
// Each accepted command spends one cycle in the access stage driving the
// memory; the response is registered on the edge ending that cycle.
//
// Build option: DMEM_ARB_FIXED_PRIO_EN
//   defined   : port A always wins a conflict, no round-robin pointer
//   undefined : round-robin between A and B
module dmem_arbiter #(
   parameter int ADDR_BITS  = 22,
   parameter int DMEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [31:0]          a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [31:0]          a_rdata,
   output logic                 a_err,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [31:0]          b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [31:0]          b_rdata,
   output logic                 b_err,
   output logic [ADDR_BITS-1:0] mem_address,
   output logic [31:0]          mem_dataIn,
   output logic                 mem_writeEnable,
   input  logic [31:0]          mem_dataOut
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   // One extra bit so a depth equal to 2**ADDR_BITS still compares correctly
   localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS+1)'(DMEM_DEPTH);

   state_t                 state_q, state_d;
   logic                   sel_q, sel_d;
   logic                   we_q, we_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;

   logic                   a_rvalid_q, a_rvalid_d;
   logic [31:0]            a_rdata_q, a_rdata_d;
   logic                   a_err_q, a_err_d;
   logic                   b_rvalid_q, b_rvalid_d;
   logic [31:0]            b_rdata_q, b_rdata_d;
   logic                   b_err_q, b_err_d;

   logic                   hs;
   logic                   stage_vld;
   logic                   in_range;
   logic [31:0]            rsp_data;

   // ---------------- arbitration ----------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
   always_comb begin
      a_gnt = reset & a_req;
      b_gnt = reset & b_req & ~a_req;
   end
`else
   // ptr_q = 0 prefers A, 1 prefers B
   logic ptr_q, ptr_d;

   always_comb begin
      a_gnt = reset & a_req & (~b_req | ~ptr_q);
      b_gnt = reset & b_req & (~a_req | ptr_q);
      ptr_d = ptr_q;
      if (a_gnt) begin
         ptr_d = 1'b1;
      end else if (b_gnt) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign hs = a_gnt | b_gnt;

   // ---------------- access stage ----------------
   assign stage_vld = (state_q == ACCESS);
   assign in_range  = ({1'b0, addr_q} < DEPTH_LIM);

   // Writes and out-of-range accesses return zero data
   assign rsp_data  = (!we_q && in_range) ? mem_dataOut : 32'h0;

   always_comb begin
      state_d    = IDLE;
      sel_d      = sel_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      a_rvalid_d = 1'b0;
      a_rdata_d  = a_rdata_q;
      a_err_d    = a_err_q;
      b_rvalid_d = 1'b0;
      b_rdata_d  = b_rdata_q;
      b_err_d    = b_err_q;

      // IDLE->ACCESS and ACCESS->ACCESS on any handshake
      if (hs) begin
         state_d = ACCESS;
         sel_d   = b_gnt;
         we_d    = b_gnt ? b_we    : a_we;
         addr_d  = b_gnt ? b_addr  : a_addr;
         wdata_d = b_gnt ? b_wdata : a_wdata;
      end

      if (stage_vld) begin
         if (sel_q) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = rsp_data;
            b_err_d    = ~in_range;
         end else begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = rsp_data;
            a_err_d    = ~in_range;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         a_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         a_err_q    <= 1'b0;
         b_rvalid_q <= 1'b0;
         b_rdata_q  <= '0;
         b_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         a_rvalid_q <= a_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         a_err_q    <= a_err_d;
         b_rvalid_q <= b_rvalid_d;
         b_rdata_q  <= b_rdata_d;
         b_err_q    <= b_err_d;
      end
   end

   // ---------------- outputs ----------------
   // Address/data hold their last command outside access cycles
   assign mem_address     = addr_q;
   assign mem_dataIn      = wdata_q;
   assign mem_writeEnable = stage_vld & we_q & in_range;

   assign a_rvalid = a_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign a_err    = a_err_q;
   assign b_rvalid = b_rvalid_q;
   assign b_rdata  = b_rdata_q;
   assign b_err    = b_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-requester
// traffic plus hand sequences for reset, contention and reset mid-flight.
module tb_dmem_arbiter;

   localparam int AB = 22;
`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          a_req, a_we, b_req, b_we;
   logic [AB-1:0] a_addr, b_addr;
   logic [31:0]   a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, a_err;
   logic          b_gnt, b_rvalid, b_err;
   logic [31:0]   a_rdata, b_rdata;
   logic [AB-1:0] mem_address;
   logic [31:0]   mem_dataIn, mem_dataOut;
   logic          mem_writeEnable;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .a_req           (a_req),
      .a_we            (a_we),
      .a_addr          (a_addr),
      .a_wdata         (a_wdata),
      .a_gnt           (a_gnt),
      .a_rvalid        (a_rvalid),
      .a_rdata         (a_rdata),
      .a_err           (a_err),
      .b_req           (b_req),
      .b_we            (b_we),
      .b_addr          (b_addr),
      .b_wdata         (b_wdata),
      .b_gnt           (b_gnt),
      .b_rvalid        (b_rvalid),
      .b_rdata         (b_rdata),
      .b_err           (b_err),
      .mem_address     (mem_address),
      .mem_dataIn      (mem_dataIn),
      .mem_writeEnable (mem_writeEnable),
      .mem_dataOut     (mem_dataOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural data memory; reloaded with a known pattern while in reset.
   // Out-of-range reads return a marker so a zeroed response is visible.
   logic [31:0] tbmem [256];

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) tbmem[i] <= 32'hA500_0000 | i;
      end else if (mem_writeEnable && mem_address < 256) begin
         tbmem[mem_address[7:0]] <= mem_dataIn;
      end
   end

   assign mem_dataOut = (mem_address < 256) ?
                        tbmem[mem_address[7:0]] : 32'hBAD0_BAD0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // cmd: 0 none, 1 read, 2 write ; gnt: 0 none, 1 A, 2 B
   typedef struct {
      int          ac;
      int          aa;
      logic [31:0] ad;
      int          bc;
      int          ba;
      logic [31:0] bd;
      int          g;
      int          we;
      int          addr;
      int          arv;
      logic [31:0] ard;
      int          aerr;
      int          brv;
      logic [31:0] brd;
      int          berr;
   } vec_t;

   function automatic vec_t row(
      input int ac, input int aa, input logic [31:0] ad,
      input int bc, input int ba, input logic [31:0] bd,
      input int g, input int we, input int addr,
      input int arv, input logic [31:0] ard, input int aerr,
      input int brv, input logic [31:0] brd, input int berr);
      vec_t v;
      v.ac = ac; v.aa = aa; v.ad = ad;
      v.bc = bc; v.ba = ba; v.bd = bd;
      v.g = g; v.we = we; v.addr = addr;
      v.arv = arv; v.ard = ard; v.aerr = aerr;
      v.brv = brv; v.brd = brd; v.berr = berr;
      return v;
   endfunction

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic apply_row(input vec_t v, input int k);
      @(negedge clk);
      a_req   = (v.ac != 0);
      a_we    = (v.ac == 2);
      a_addr  = AB'(v.aa);
      a_wdata = v.ad;
      b_req   = (v.bc != 0);
      b_we    = (v.bc == 2);
      b_addr  = AB'(v.ba);
      b_wdata = v.bd;
      #2;
      chk($sformatf("r%0d a_gnt", k), 32'(a_gnt), 32'(v.g == 1));
      chk($sformatf("r%0d b_gnt", k), 32'(b_gnt), 32'(v.g == 2));
      chk($sformatf("r%0d mem_we", k), 32'(mem_writeEnable), 32'(v.we));
      chk($sformatf("r%0d mem_addr", k), 32'(mem_address), 32'(v.addr));
      chk($sformatf("r%0d a_rvalid", k), 32'(a_rvalid), 32'(v.arv));
      chk($sformatf("r%0d a_rdata", k), a_rdata, v.ard);
      chk($sformatf("r%0d a_err", k), 32'(a_err), 32'(v.aerr));
      chk($sformatf("r%0d b_rvalid", k), 32'(b_rvalid), 32'(v.brv));
      chk($sformatf("r%0d b_rdata", k), b_rdata, v.brd);
      chk($sformatf("r%0d b_err", k), 32'(b_err), 32'(v.berr));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " a_gnt"}, 32'(a_gnt), 0);
      chk({nm, " b_gnt"}, 32'(b_gnt), 0);
      chk({nm, " a_rvalid"}, 32'(a_rvalid), 0);
      chk({nm, " b_rvalid"}, 32'(b_rvalid), 0);
      chk({nm, " a_rdata"}, a_rdata, 0);
      chk({nm, " b_rdata"}, b_rdata, 0);
      chk({nm, " a_err"}, 32'(a_err), 0);
      chk({nm, " b_err"}, 32'(b_err), 0);
      chk({nm, " mem_addr"}, 32'(mem_address), 0);
      chk({nm, " mem_din"}, mem_dataIn, 0);
      chk({nm, " mem_we"}, 32'(mem_writeEnable), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
   endtask

   localparam int N = 0, R = 1, W = 2;
   localparam int GA = 1, GB = 2;
   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CF = 32'hCAFEF00D;

   vec_t vecs [20];
   int   exp_g [4];

   initial begin
      vecs[0]  = row(W,5,DB,   N,0,0,       GA,0,0,   0,0,0,   0,0,0);
      vecs[1]  = row(R,5,0,    N,0,0,       GA,1,5,   0,0,0,   0,0,0);
      vecs[2]  = row(N,0,0,    N,0,0,       0,0,5,    1,0,0,   0,0,0);
      vecs[3]  = row(N,0,0,    W,300,'h1234,GB,0,5,   1,DB,0,  0,0,0);
      vecs[4]  = row(N,0,0,    N,0,0,       0,0,300,  0,DB,0,  0,0,0);
      vecs[5]  = row(N,0,0,    N,0,0,       0,0,300,  0,DB,0,  1,0,1);
      vecs[6]  = row(W,7,'h55, N,0,0,       GA,0,300, 0,DB,0,  0,0,1);
      vecs[7]  = row(R,7,0,    N,0,0,       GA,1,7,   0,DB,0,  0,0,1);
      vecs[8]  = row(N,0,0,    R,7,0,       GB,0,7,   1,0,0,   0,0,1);
      vecs[9]  = row(N,0,0,    N,0,0,       0,0,7,    1,'h55,0,0,0,1);
      vecs[10] = row(N,0,0,    N,0,0,       0,0,7,    0,'h55,0,1,'h55,0);
      vecs[11] = row(N,0,0,    R,300,0,     GB,0,7,   0,'h55,0,0,'h55,0);
      vecs[12] = row(N,0,0,    N,0,0,       0,0,300,  0,'h55,0,0,'h55,0);
      vecs[13] = row(N,0,0,    N,0,0,       0,0,300,  0,'h55,0,1,0,1);
      vecs[14] = row(W,255,CF, N,0,0,       GA,0,300, 0,'h55,0,0,0,1);
      vecs[15] = row(R,255,0,  N,0,0,       GA,1,255, 0,'h55,0,0,0,1);
      vecs[16] = row(R,256,0,  N,0,0,       GA,0,255, 1,0,0,   0,0,1);
      vecs[17] = row(N,0,0,    N,0,0,       0,0,256,  1,CF,0,  0,0,1);
      vecs[18] = row(N,0,0,    N,0,0,       0,0,256,  1,0,1,   0,0,1);
      vecs[19] = row(N,0,0,    N,0,0,       0,0,256,  0,0,1,   0,0,1);

      if (FIXED) begin
         exp_g = '{0, 0, 0, 1};
      end else begin
         exp_g = '{0, 1, 0, 1};
      end

      // Reset: gnt suppressed even with both ports requesting
      reset = 0;
      idle_inputs();
      a_req = 1;
      b_req = 1;
      #3;
      chk_all_zero("rst");
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      reset = 1;

      // Single-requester traffic
      for (int k = 0; k < 20; k++) apply_row(vecs[k], k);

      // Reset asserted while an A read sits in the access stage
      do_reset();
      @(negedge clk);
      a_req = 1; a_we = 0; a_addr = 3;
      #2;
      chk("drop a_gnt", 32'(a_gnt), 1);
      @(negedge clk);
      idle_inputs();
      a_req = 1; b_req = 1;
      #1;
      reset = 0;
      #1;
      chk_all_zero("drop");
      @(negedge clk);
      idle_inputs();
      reset = 1;
      #2;
      chk("drop rv0", 32'(a_rvalid), 0);
      @(negedge clk);
      a_req = 1; a_addr = 3; b_req = 1; b_addr = 4;
      #2;
      chk("drop rv1", 32'(a_rvalid), 0);
      chk("post a_gnt", 32'(a_gnt), 1);
      chk("post b_gnt", 32'(b_gnt), 0);

      // Contention, starting from the reset pointer
      do_reset();
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         idle_inputs();
         a_req  = FIXED ? (j < 3) : (j < 4);
         a_addr = 3;
         b_req  = (j < 4);
         b_addr = 4;
         #2;
         chk($sformatf("c%0d a_gnt", j), 32'(a_gnt),
             32'(j < 4 && exp_g[j % 4] == 0));
         chk($sformatf("c%0d b_gnt", j), 32'(b_gnt),
             32'(j < 4 && exp_g[j % 4] == 1));
         chk($sformatf("c%0d both", j), 32'(a_gnt & b_gnt), 0);
         if (j >= 2) begin
            chk($sformatf("c%0d a_rv", j), 32'(a_rvalid),
                32'(exp_g[j-2] == 0));
            chk($sformatf("c%0d b_rv", j), 32'(b_rvalid),
                32'(exp_g[j-2] == 1));
            if (exp_g[j-2] == 0)
               chk($sformatf("c%0d a_rd", j), a_rdata, 32'hA5000003);
            else
               chk($sformatf("c%0d b_rd", j), b_rdata, 32'hA5000004);
         end else begin
            chk($sformatf("c%0d a_rv", j), 32'(a_rvalid), 0);
            chk($sformatf("c%0d b_rv", j), 32'(b_rvalid), 0);
         end
      end

      @(negedge clk);
      idle_inputs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
